// File: rtl/btn_step_pkg.sv
// Shared constants for the button/step controller and the LED ring sequencer.
// Holds the FSM state encoding and the 27 MHz-derived default cycle counts.
package btn_step_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FWD  = 2'b01,
        ST_REV  = 2'b10
    } state_t;

    localparam int CLK_HZ          = 27_000_000;
    localparam int DEB_CYCLES_DEF  = CLK_HZ / 100;   // 10 ms
    localparam int TICK_CYCLES_DEF = CLK_HZ / 2;     // 0.5 s
    localparam int CNT_W_DEF       = 26;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-level debounce counter and press pulse
// for one active-low push button.
module btn_debounce #(
    parameter int DEB_CYCLES = 270000,
    parameter int CNT_W      = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            // only a released->pressed change of the debounced level yields a pulse
            press    <= stable_d & ~stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/btn_step_ctrl.sv
// Button-driven run/direction FSM with a step_en clock-enable generator.
// Optional: BTN_STEP_STOP_ON_REPRESS_EN makes a re-press of the active direction stop stepping.
//
//  state   | meaning
//  ST_IDLE | stopped, no step_en, dir holds last value
//  ST_FWD  | stepping forward (dir=1)
//  ST_REV  | stepping in reverse (dir=0)
import btn_step_pkg::*;

module btn_step_ctrl #(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int TICK_CYCLES = TICK_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic p1,
    input  logic p2,
    output logic step_en,
    output logic dir,
    output logic run
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);

    logic             p1_press;
    logic             p2_press;
    state_t           state;
    logic [CNT_W-1:0] tick_cnt;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_p1 (
        .clk   (clk),
        .rst   (rst),
        .btn   (p1),
        .press (p1_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_p2 (
        .clk   (clk),
        .rst   (rst),
        .btn   (p2),
        .press (p2_press)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            step_en  <= 1'b0;
            dir      <= 1'b1;
            run      <= 1'b0;
        end else begin
            step_en <= 1'b0;
            // simultaneous presses fall through to the counting branch untouched
            if (p1_press && !p2_press && state != ST_FWD) begin
                state    <= ST_FWD;
                dir      <= 1'b1;
                run      <= 1'b1;
                tick_cnt <= '0;
            end else if (p2_press && !p1_press && state != ST_REV) begin
                state    <= ST_REV;
                dir      <= 1'b0;
                run      <= 1'b1;
                tick_cnt <= '0;
            end
`ifdef BTN_STEP_STOP_ON_REPRESS_EN
            else if ((p1_press && !p2_press && state == ST_FWD) ||
                     (p2_press && !p1_press && state == ST_REV)) begin
                state    <= ST_IDLE;
                run      <= 1'b0;
                tick_cnt <= '0;
            end
`endif
            else if (run) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    step_en  <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + CNT_W'(1);
                end
            end else begin
                tick_cnt <= '0;
            end
        end
    end

endmodule
